vga_timing_gen: RTL

- Free-running 640x480@60 Hz VGA raster timing generator.
- Produces the pixel coordinates DrawX/DrawY and the active-video flag blank that every sprite/ROM drawer consumes. Drawers treat blank=1 as "output palette colour".
- Also produces hs/vs sync, frame and vblank event pulses for game logic.
- Provides sync/blank copies delayed to match the drawers' ROM-read plus output-register latency.

---
 rtl/vga_timing_pkg.sv | 34 +++
 rtl/vga_sync_delay.sv | 51 +++++
 rtl/vga_timing_gen.sv | 109 ++++++++++
 3 files changed

// File: rtl/vga_timing_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------
// vga_timing_pkg - coordinate type and 640x480@60 raster constants
// Revision: 1.0
// ----------------------------------------------------------------------
package vga_timing_pkg;

  typedef logic [9:0] coord_t;

  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;

  localparam int H_TOTAL  = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
  localparam int V_TOTAL  = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;
  localparam int HS_START = H_ACTIVE_DEF + H_FP_DEF;
  localparam int HS_END   = HS_START + H_SYNC_DEF;
  localparam int VS_START = V_ACTIVE_DEF + V_FP_DEF;
  localparam int VS_END   = VS_START + V_SYNC_DEF;

  // Idle pattern of the {hs, vs, blank} bundle: syncs inactive, video dark.
  localparam logic [2:0] SYNC_IDLE = 3'b110;

  function automatic coord_t to_coord(input int v);
    return coord_t'(v);
  endfunction

endpackage
`default_nettype wire

// File: rtl/vga_sync_delay.sv
`default_nettype none
// ----------------------------------------------------------------------
// vga_sync_delay - DEPTH-stage shift register for the {hs, vs, blank} bundle
// Revision: 1.0
// ----------------------------------------------------------------------
module vga_sync_delay
  import vga_timing_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] din,
  output logic [2:0] dout
);

  generate
    if (DEPTH == 0) begin : g_bypass
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ rst_n;
      assign dout           = din;
    end else begin : g_pipe
      logic [2:0] stage_q [DEPTH];
      logic [2:0] stage_d [DEPTH];

      always_comb begin
        stage_d[0] = din;
        for (int i = 1; i < DEPTH; i++) begin
          stage_d[i] = stage_q[i-1];
        end
      end

      // Reset flushes every stage to idle rather than letting it drain.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < DEPTH; i++) begin
            stage_q[i] <= SYNC_IDLE;
          end
        end else begin
          for (int i = 0; i < DEPTH; i++) begin
            stage_q[i] <= stage_d[i];
          end
        end
      end

      assign dout = stage_q[DEPTH-1];
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ----------------------------------------------------------------------
// vga_timing_gen - free-running VGA raster counters, sync/blank decode
// Revision: 1.0
// ----------------------------------------------------------------------
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE   = H_ACTIVE_DEF,
  parameter int H_FP       = H_FP_DEF,
  parameter int H_SYNC     = H_SYNC_DEF,
  parameter int H_BP       = H_BP_DEF,
  parameter int V_ACTIVE   = V_ACTIVE_DEF,
  parameter int V_FP       = V_FP_DEF,
  parameter int V_SYNC     = V_SYNC_DEF,
  parameter int V_BP       = V_BP_DEF,
  parameter int PIPE_DELAY = 2
) (
  input  logic       vga_clk,
  input  logic       reset_n,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       blank,
  output logic       hs,
  output logic       vs,
  output logic       frame_start,
  output logic       vblank_start,
  output logic       hs_d,
  output logic       vs_d,
  output logic       blank_d
);

  localparam coord_t H_LAST = to_coord(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam coord_t V_LAST = to_coord(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam coord_t H_VIS  = to_coord(H_ACTIVE);
  localparam coord_t V_VIS  = to_coord(V_ACTIVE);
  localparam coord_t HS_LO  = to_coord(H_ACTIVE + H_FP);
  localparam coord_t HS_HI  = to_coord(H_ACTIVE + H_FP + H_SYNC);
  localparam coord_t VS_LO  = to_coord(V_ACTIVE + V_FP);
  localparam coord_t VS_HI  = to_coord(V_ACTIVE + V_FP + V_SYNC);

  coord_t     x_q, x_d;
  coord_t     y_q, y_d;
  logic       act_q, act_d;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic       fstart_q, fstart_d;
  logic       vbstart_q, vbstart_d;
  logic [2:0] sync_dly;

  // Decode from the next-state coordinates so every flag lines up with DrawX/DrawY.
  always_comb begin
    x_d = x_q + 10'd1;
    y_d = y_q;
    if (x_q == H_LAST) begin
      x_d = '0;
      if (y_q == V_LAST) begin
        y_d = '0;
      end else begin
        y_d = y_q + 10'd1;
      end
    end
    act_d     = (x_d < H_VIS) && (y_d < V_VIS);
    hsync_d   = !((x_d >= HS_LO) && (x_d < HS_HI));
    vsync_d   = !((y_d >= VS_LO) && (y_d < VS_HI));
    fstart_d  = (x_d == '0) && (y_d == '0);
    vbstart_d = (x_d == '0) && (y_d == V_VIS);
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      x_q       <= '0;
      y_q       <= '0;
      act_q     <= 1'b0;
      hsync_q   <= 1'b1;
      vsync_q   <= 1'b1;
      fstart_q  <= 1'b0;
      vbstart_q <= 1'b0;
    end else begin
      x_q       <= x_d;
      y_q       <= y_d;
      act_q     <= act_d;
      hsync_q   <= hsync_d;
      vsync_q   <= vsync_d;
      fstart_q  <= fstart_d;
      vbstart_q <= vbstart_d;
    end
  end

  vga_sync_delay #(
    .DEPTH (PIPE_DELAY)
  ) u_sync_delay (
    .clk   (vga_clk),
    .rst_n (reset_n),
    .din   ({hsync_q, vsync_q, act_q}),
    .dout  (sync_dly)
  );

  assign DrawX                   = x_q;
  assign DrawY                   = y_q;
  assign blank                   = act_q;
  assign hs                      = hsync_q;
  assign vs                      = vsync_q;
  assign frame_start             = fstart_q;
  assign vblank_start            = vbstart_q;
  assign {hs_d, vs_d, blank_d}   = sync_dly;

endmodule
`default_nettype wire
